// File: rtl/farm_road_sensor_pkg.sv
// Shared definitions for the farm-road detector front end: state encodings
// and default parameter values, reused by the light controller and timer.
package farm_road_sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int CNT_W_DEF           = 4;
    localparam int DEBOUNCE_CNT_W      = 8;

endpackage

// File: rtl/det_debounce.sv
// Two-flop synchronizer followed by a stable-count filter. The clean output
// only changes after DEBOUNCE_CYCLES consecutive samples disagree with it.
// Also intended for the future pedestrian push button.
module det_debounce
    import farm_road_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic det_raw,
    output logic det_clean
);

    localparam logic [DEBOUNCE_CNT_W-1:0] TERM_CNT = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync_1;
    logic                      det_s;
    logic [DEBOUNCE_CNT_W-1:0] stable_cnt;

    // Synchronize the raw detector, then count consecutive mismatching samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            det_s      <= 1'b0;
            det_clean  <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync_1 <= det_raw;
            det_s  <= sync_1;
            if (det_s == det_clean) begin
                stable_cnt <= '0;
            end else if (stable_cnt == TERM_CNT) begin
                det_clean  <= ~det_clean;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + DEBOUNCE_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/farm_road_sensor.sv
// Farm-road vehicle detector front end. Turns the debounced loop detector
// into the car-present request c, counting queued vehicles until the light
// controller's farm green (fg) has served every one of them.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no car waiting, c low; fg ignored
//   ST_WAIT  | cars queued, farm road red; waiting for fg
//   ST_SERVE | farm road green; departures drain the queue
module farm_road_sensor
    import farm_road_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             det_raw,
    input  logic             fg,
    output logic             c,
    output logic [CNT_W-1:0] queue,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] QUEUE_MAX = '1;

    state_t           state;
    logic             det_clean;
    logic             det_clean_d;
    logic             arrival;
    logic             departure;
    logic [CNT_W-1:0] queue_nxt;
    logic             ovf_set;

    det_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_det_debounce (
        .clk       (clk),
        .reset     (reset),
        .det_raw   (det_raw),
        .det_clean (det_clean)
    );

    // Registered edge detect; events are presented one cycle after det_clean moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            det_clean_d <= 1'b0;
            arrival     <= 1'b0;
            departure   <= 1'b0;
        end else begin
            det_clean_d <= det_clean;
            arrival     <= det_clean & ~det_clean_d;
            departure   <= ~det_clean & det_clean_d;
        end
    end

    // Next queue value: saturating increment on arrival, floored decrement on a served departure.
    always_comb begin
        queue_nxt = queue;
        ovf_set   = 1'b0;
        if (arrival) begin
            if (queue == QUEUE_MAX) begin
                ovf_set = 1'b1;
            end else begin
                queue_nxt = queue + CNT_W'(1);
            end
        end
        if (departure && (state == ST_SERVE) && (queue_nxt != '0)) begin
            queue_nxt = queue_nxt - CNT_W'(1);
        end
    end

    // Queue counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            queue    <= '0;
            overflow <= 1'b0;
        end else begin
            queue    <= queue_nxt;
            overflow <= overflow | ovf_set;
        end
    end

    // Service FSM; c is registered from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            c     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arrival) begin
                        state <= ST_WAIT;
                        c     <= 1'b1;
                    end else begin
                        c <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    c <= 1'b1;
                    if (fg) begin
                        state <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    // Exit uses the already-decremented queue, so a last
                    // departure coinciding with fg falling goes straight to idle.
                    if (queue_nxt == '0) begin
                        state <= ST_IDLE;
                        c     <= 1'b0;
                    end else begin
                        c <= 1'b1;
                        if (!fg) begin
                            state <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    c     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_farm_road_sensor.sv
// Bench for farm_road_sensor: two instances (default sizing and a short
// debounce with a 2-bit queue) share stimulus and are compared every cycle
// against a window-based behavioural model, plus directed checkpoints.
module tb_farm_road_sensor;

    localparam int D_A = 16;
    localparam int W_A = 4;
    localparam int D_B = 4;
    localparam int W_B = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           det_raw;
    logic           fg;
    logic           c_a, ov_a;
    logic [W_A-1:0] q_a;
    logic           c_b, ov_b;
    logic [W_B-1:0] q_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    farm_road_sensor #(.DEBOUNCE_CYCLES(D_A), .CNT_W(W_A)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .det_raw  (det_raw),
        .fg       (fg),
        .c        (c_a),
        .queue    (q_a),
        .overflow (ov_a)
    );

    farm_road_sensor #(.DEBOUNCE_CYCLES(D_B), .CNT_W(W_B)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .det_raw  (det_raw),
        .fg       (fg),
        .c        (c_b),
        .queue    (q_b),
        .overflow (ov_b)
    );

    // ---------------- reference model ----------------
    int m_d[2]   = '{D_A, D_B};
    int m_max[2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    bit raw_h1[2], raw_h2[2];        // raw sampled one / two edges ago
    bit win[2][$];                   // most recent synchronized samples
    bit cl1[2], cl2[2], cl3[2];      // clean level after edges k-1, k-2, k-3
    int mq[2];
    bit mov[2];
    bit mreq[2];                     // a car is being requested
    bit msrv[2];                     // farm road currently serving

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            raw_h1[i] = 0; raw_h2[i] = 0;
            win[i].delete();
            cl1[i] = 0; cl2[i] = 0; cl3[i] = 0;
            mq[i] = 0; mov[i] = 0; mreq[i] = 0; msrv[i] = 0;
        end
    endfunction

    function automatic void model_edge(input bit raw, input bit fgv, input bit rst);
        bit arr, dep, alldiff, newcl;
        int nq;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            arr = cl2[i] && !cl3[i];
            dep = !cl2[i] && cl3[i];
            nq = mq[i];
            if (arr) begin
                if (nq == m_max[i]) mov[i] = 1;
                else nq = nq + 1;
            end
            if (dep && msrv[i] && nq > 0) nq = nq - 1;
            if (!mreq[i]) begin
                if (arr) mreq[i] = 1;
            end else if (!msrv[i]) begin
                if (fgv) msrv[i] = 1;
            end else if (nq == 0) begin
                mreq[i] = 0;
                msrv[i] = 0;
            end else if (!fgv) begin
                msrv[i] = 0;
            end
            mq[i] = nq;
            // clean level flips once the last D synchronized samples all disagree with it
            win[i].push_back(raw_h2[i]);
            if (win[i].size() > m_d[i]) void'(win[i].pop_front());
            alldiff = (win[i].size() == m_d[i]);
            for (int j = 0; j < win[i].size(); j++)
                if (win[i][j] == cl1[i]) alldiff = 0;
            newcl = alldiff ? !cl1[i] : cl1[i];
            cl3[i] = cl2[i]; cl2[i] = cl1[i]; cl1[i] = newcl;
            raw_h2[i] = raw_h1[i]; raw_h1[i] = raw;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("c_a",  8'(c_a),  8'(mreq[0]));
        chk("q_a",  8'(q_a),  8'(mq[0]));
        chk("ov_a", 8'(ov_a), 8'(mov[0]));
        chk("c_b",  8'(c_b),  8'(mreq[1]));
        chk("q_b",  8'(q_b),  8'(mq[1]));
        chk("ov_b", 8'(ov_b), 8'(mov[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(det_raw, fg, reset);
        @(negedge clk);
        check_all();
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int raw_left, fg_left;
        model_reset();
        reset   = 1'b1;
        det_raw = 1'b1;
        fg      = 1'b0;

        // reset values with the detector already high, then exact latency
        hold(3);
        chk("rst_c", 8'(c_a), 8'd0);
        chk("rst_q", 8'(q_a), 8'd0);
        chk("rst_ov", 8'(ov_a), 8'd0);
        reset = 1'b0;
        hold(19);
        chk("lat_c_edge18", 8'(c_a), 8'd0);
        tick();
        chk("lat_c_edge19", 8'(c_a), 8'd1);
        chk("lat_q_edge19", 8'(q_a), 8'd1);

        // glitch rejection: 15 cycles rejected, 16 accepted
        reset = 1'b1; det_raw = 1'b0; tick();
        reset = 1'b0; hold(5);
        det_raw = 1'b1; hold(15);
        det_raw = 1'b0; hold(30);
        chk("glitch15_q", 8'(q_a), 8'd0);
        chk("glitch15_c", 8'(c_a), 8'd0);
        det_raw = 1'b1; hold(16);
        det_raw = 1'b0; hold(30);
        chk("pulse16_q", 8'(q_a), 8'd1);
        chk("pulse16_c", 8'(c_a), 8'd1);

        // last departure under green drops c with the queue
        reset = 1'b1; tick();
        reset = 1'b0;
        det_raw = 1'b1; hold(25);
        fg = 1'b1; hold(2);
        det_raw = 1'b0; hold(25);
        chk("served_q", 8'(q_a), 8'd0);
        chk("served_c", 8'(c_a), 8'd0);
        fg = 1'b0;

        // green ends early with a car left, then reset mid-service
        reset = 1'b1; tick();
        reset = 1'b0;
        det_raw = 1'b1; hold(25);
        det_raw = 1'b0; hold(25);
        det_raw = 1'b1; hold(25);
        chk("two_cars_q", 8'(q_a), 8'd2);
        fg = 1'b1; hold(2);
        det_raw = 1'b0; hold(25);
        chk("one_served_q", 8'(q_a), 8'd1);
        fg = 1'b0; hold(2);
        chk("early_end_q", 8'(q_a), 8'd1);
        chk("early_end_c", 8'(c_a), 8'd1);
        fg = 1'b1; hold(2);
        det_raw = 1'b1; hold(25);
        chk("serve_arr_q", 8'(q_a), 8'd2);
        reset = 1'b1; tick();
        chk("midrst_q", 8'(q_a), 8'd0);
        chk("midrst_c", 8'(c_a), 8'd0);
        reset = 1'b0; hold(19);
        chk("redetect_c_pre", 8'(c_a), 8'd0);
        tick();
        chk("redetect_q", 8'(q_a), 8'd1);
        chk("redetect_c", 8'(c_a), 8'd1);

        // saturation on the 2-bit instance
        reset = 1'b1; det_raw = 1'b0; fg = 1'b0; tick();
        reset = 1'b0; hold(5);
        repeat (4) begin
            det_raw = 1'b1; hold(8);
            det_raw = 1'b0; hold(8);
        end
        chk("sat4_q", 8'(q_b), 8'd3);
        chk("sat4_ov", 8'(ov_b), 8'd1);
        det_raw = 1'b1; hold(8);
        det_raw = 1'b0; hold(8);
        chk("sat5_q", 8'(q_b), 8'd3);
        chk("sat5_ov", 8'(ov_b), 8'd1);
        fg = 1'b1; hold(2);
        det_raw = 1'b1; hold(8);
        det_raw = 1'b0; hold(8);
        chk("sat_dep_q", 8'(q_b), 8'd2);
        chk("sat_dep_ov", 8'(ov_b), 8'd1);

        // randomized detector bounce, green windows and occasional resets
        raw_left = 0;
        fg_left  = 0;
        for (int n = 0; n < 4000; n++) begin
            if (raw_left == 0) begin
                det_raw  = ~det_raw;
                raw_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                       : int'($urandom_range(4, 40));
            end
            raw_left--;
            if (fg_left == 0) begin
                fg      = ~fg;
                fg_left = int'($urandom_range(1, 90));
            end
            fg_left--;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
